// File: rtl/lfsr_pkg.sv
// Polynomial and state definitions shared by the PRBS generator and checker,
// so both ends of the link use the same LFSR.
package lfsr_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'hEA000001;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] r);
        return ^(r & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. When clear and increment
// arrive together the count becomes 1, so the increment is not lost.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds its predictor from the stream, verifies a
// run of correct predictions, then flywheels and counts bit errors.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int LOSS_ERRS = 8,
    parameter int WINDOW    = 256,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic                rx_bit,
    input  logic                clr_cnt,
    output logic                locked,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    bit_count,
    output logic [1:0]          state,
    output logic [LFSR_W-1:0]   exp_reg
);

    localparam int FILL_W = $clog2(LFSR_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WB_W   = $clog2(WINDOW);
    localparam int WE_W   = $clog2(LOSS_ERRS + 1);

    chk_state_e         state_q, state_d;
    logic [LFSR_W-1:0]  exp_q, exp_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WB_W-1:0]    wb_q, wb_d;
    logic [WE_W-1:0]    we_q, we_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;

    logic [LFSR_W-1:0]  shifted;
    logic [WE_W-1:0]    we_next;
    logic               pred;
    logic               mism;
    logic               err_inc;
    logic               bit_inc;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        fill_d      = fill_q;
        good_d      = good_q;
        wb_d        = wb_q;
        we_d        = we_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        bit_inc     = 1'b0;
        pred        = lfsr_next_bit(exp_q);
        mism        = rx_bit ^ pred;
        shifted     = {rx_bit, exp_q[LFSR_W-1:1]};
        we_next     = we_q + WE_W'(mism);

        if (rx_valid) begin
            case (state_q)
                SEED: begin
                    exp_d = shifted;
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        fill_d = '0;
                        // An all-zero seed is the LFSR lock-up state; refill instead.
                        if (shifted != '0) begin
                            state_d = VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    exp_d = shifted;
                    if (mism) begin
                        state_d = SEED;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == GOOD_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            wb_d    = '0;
                            we_d    = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a bad bit cannot corrupt the predictor.
                    exp_d       = {pred, exp_q[LFSR_W-1:1]};
                    bit_inc     = 1'b1;
                    err_inc     = mism;
                    err_pulse_d = mism;
                    if (we_next >= WE_W'(LOSS_ERRS)) begin
                        state_d = SEED;
                        fill_d  = '0;
                        good_d  = '0;
                        wb_d    = '0;
                        we_d    = '0;
                    end else if (wb_q == WB_W'(WINDOW - 1)) begin
                        wb_d = '0;
                        we_d = '0;
                    end else begin
                        wb_d = wb_q + WB_W'(1);
                        we_d = we_next;
                    end
                end
                default: begin
                    state_d = SEED;
                    fill_d  = '0;
                    good_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            exp_q       <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            wb_q        <= '0;
            we_q        <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            wb_q        <= wb_d;
            we_q        <= we_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clr_cnt),
        .count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bit_inc),
        .clr   (clr_cnt),
        .count (bit_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign state     = state_q;
    assign exp_reg   = exp_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker driven by a reference 32-bit LFSR generator.
module tb_prbs_checker;

    localparam logic [31:0] SEED_VAL = 32'h974CA351;
    localparam logic [31:0] TAPS     = 32'hEA000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic        rx_bit = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bit_count;
    logic [1:0]  state;
    logic [31:0] exp_reg;

    logic [31:0] gen;
    int          bitn;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_CNT  (64),
        .LOSS_ERRS (8),
        .WINDOW    (256),
        .CNT_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_bit    (rx_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count),
        .state     (state),
        .exp_reg   (exp_reg)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        rx_valid = v;
        rx_bit   = b;
        clr_cnt  = c;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic send_gen(input logic inv, input logic c);
        logic b;
        b    = gen[0];
        gen  = {^(gen & TAPS), gen[31:1]};
        bitn++;
        step(1'b1, b ^ inv, c);
    endtask

    task automatic send_clean_to(input int n);
        while (bitn < n) send_gen(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst  = 1'b0;
        gen  = SEED_VAL;
        bitn = 0;
    endtask

    initial begin
        do_reset();
        chk_eq("rst_state",     32'(state), 32'd0);
        chk_eq("rst_locked",    32'(locked), 32'd0);
        chk_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk_eq("rst_err_count", err_count, 32'd0);
        chk_eq("rst_bit_count", bit_count, 32'd0);
        chk_eq("rst_exp_reg",   exp_reg, 32'd0);

        // Continuous stream: seed, verify, lock.
        send_clean_to(31);
        chk_eq("seed_31_state", 32'(state), 32'd0);
        send_clean_to(32);
        chk_eq("seed_32_state", 32'(state), 32'd1);
        chk_eq("seed_32_exp",   exp_reg, SEED_VAL);
        send_clean_to(95);
        chk_eq("verify_95_locked", 32'(locked), 32'd0);
        send_clean_to(96);
        chk_eq("lock_96_locked", 32'(locked), 32'd1);
        chk_eq("lock_96_state",  32'(state), 32'd2);
        chk_eq("lock_96_errs",   err_count, 32'd0);

        // Single error at bit 300 while locked.
        send_clean_to(299);
        send_gen(1'b1, 1'b0);
        chk_eq("err300_pulse",  32'(err_pulse), 32'd1);
        chk_eq("err300_count",  err_count, 32'd1);
        chk_eq("err300_bits",   bit_count, 32'd204);
        chk_eq("err300_locked", 32'(locked), 32'd1);
        send_gen(1'b0, 1'b0);
        chk_eq("err301_pulse",  32'(err_pulse), 32'd0);
        send_clean_to(320);
        chk_eq("fly320_count",  err_count, 32'd1);
        chk_eq("fly320_bits",   bit_count, 32'd224);

        // Clear during a gap, then 8 errors in one window drop lock.
        send_clean_to(360);
        step(1'b0, 1'b0, 1'b1);
        chk_eq("clr_gap_errs", err_count, 32'd0);
        chk_eq("clr_gap_bits", bit_count, 32'd0);
        for (int k = 0; k < 7; k++) begin
            send_gen(1'b1, 1'b0);
            send_gen(1'b0, 1'b0);
        end
        chk_eq("loss7_locked", 32'(locked), 32'd1);
        chk_eq("loss7_errs",   err_count, 32'd7);
        send_gen(1'b1, 1'b0);
        chk_eq("loss8_bitn",   32'(bitn), 32'd375);
        chk_eq("loss8_locked", 32'(locked), 32'd0);
        chk_eq("loss8_state",  32'(state), 32'd0);
        chk_eq("loss8_errs",   err_count, 32'd8);
        chk_eq("loss8_pulse",  32'(err_pulse), 32'd1);
        chk_eq("loss8_bits",   bit_count, 32'd15);

        // Relock after 96 more clean bits; counters retained.
        send_clean_to(470);
        chk_eq("relock_470_locked", 32'(locked), 32'd0);
        send_clean_to(471);
        chk_eq("relock_471_locked", 32'(locked), 32'd1);
        chk_eq("relock_errs",       err_count, 32'd8);
        chk_eq("relock_bits",       bit_count, 32'd15);

        // Clear coinciding with an error increment.
        send_gen(1'b1, 1'b1);
        chk_eq("clr_inc_errs",  err_count, 32'd1);
        chk_eq("clr_inc_bits",  bit_count, 32'd1);
        chk_eq("clr_inc_pulse", 32'(err_pulse), 32'd1);

        // Reset mid-lock with an erroneous valid bit on the same edge.
        rst = 1'b1;
        send_gen(1'b1, 1'b0);
        rst = 1'b0;
        chk_eq("midrst_state",  32'(state), 32'd0);
        chk_eq("midrst_locked", 32'(locked), 32'd0);
        chk_eq("midrst_pulse",  32'(err_pulse), 32'd0);
        chk_eq("midrst_errs",   err_count, 32'd0);
        chk_eq("midrst_bits",   bit_count, 32'd0);
        chk_eq("midrst_exp",    exp_reg, 32'd0);

        // Same stream with rx_valid toggling 1/0.
        do_reset();
        while (bitn < 32) begin
            send_gen(1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        chk_eq("gap32_state", 32'(state), 32'd1);
        chk_eq("gap32_exp",   exp_reg, SEED_VAL);
        while (bitn < 95) begin
            send_gen(1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        chk_eq("gap95_locked", 32'(locked), 32'd0);
        send_gen(1'b0, 1'b0);
        chk_eq("gap96_locked", 32'(locked), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk_eq("gap96_hold_locked", 32'(locked), 32'd1);
        chk_eq("gap96_bits",        bit_count, 32'd0);
        send_gen(1'b1, 1'b0);
        chk_eq("gap97_pulse", 32'(err_pulse), 32'd1);
        chk_eq("gap97_errs",  err_count, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk_eq("gap97_pulse_drop", 32'(err_pulse), 32'd0);
        chk_eq("gap97_errs_hold",  err_count, 32'd1);
        chk_eq("gap97_bits_hold",  bit_count, 32'd1);

        // Error during VERIFY is silent and returns to SEED.
        do_reset();
        send_clean_to(49);
        chk_eq("ver49_state", 32'(state), 32'd1);
        send_gen(1'b1, 1'b0);
        chk_eq("ver50_state", 32'(state), 32'd0);
        chk_eq("ver50_pulse", 32'(err_pulse), 32'd0);
        chk_eq("ver50_errs",  err_count, 32'd0);

        // Constant-zero stream never leaves SEED.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0);
        chk_eq("zero32_state", 32'(state), 32'd0);
        for (int i = 32; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        chk_eq("zero100_state",  32'(state), 32'd0);
        chk_eq("zero100_locked", 32'(locked), 32'd0);
        chk_eq("zero100_exp",    exp_reg, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
